// File: rtl/gnrl_fifo_pkg.sv
// Shared constants for the general storage library FIFO.
package gnrl_fifo_pkg;
  localparam int GNRL_HSK_W = 1;
endpackage

// File: rtl/gnrl_fifo_ptr.sv
// Wrapping pointer counter for gnrl_fifo: increments on enable, async clear to zero.
module gnrl_fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;

  always_comb ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/gnrl_fifo.sv
// General synchronous valid/ready FIFO. Define GNRL_FIFO_BYPASS_EN for 0-cycle
// pass-through when empty; FPGA_SOURCE drops the simulation-only X check.
module gnrl_fifo
  import gnrl_fifo_pkg::*;
#(
  parameter  int DW = 32,
  parameter  int DP = 4,
  localparam int AW = $clog2(DP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GNRL_HSK_W-1:0] i_vld,
  output logic [GNRL_HSK_W-1:0] i_rdy,
  input  logic [DW-1:0]         i_dat,
  output logic [GNRL_HSK_W-1:0] o_vld,
  input  logic [GNRL_HSK_W-1:0] o_rdy,
  output logic [DW-1:0]         o_dat,
  output logic [AW:0]           cnt,
  output logic                  full,
  output logic                  empty
);
  logic [AW:0]          wptr, rptr;
  logic [DP-1:0][DW-1:0] mem_q;
  logic                 push, pop, byp, wr_en;

  // Extra MSB on each pointer tells a full ring apart from an empty one.
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) & (wptr[AW] != rptr[AW]);
  assign empty = (wptr == rptr);
  assign cnt   = wptr - rptr;
  assign i_rdy = ~full;
  assign push  = i_vld & i_rdy;
  assign pop   = ~empty & o_rdy;

`ifdef GNRL_FIFO_BYPASS_EN
  assign byp   = empty & i_vld & o_rdy;
  assign o_vld = ~empty | i_vld;
  assign o_dat = empty ? i_dat : mem_q[rptr[AW-1:0]];
`else
  assign byp   = 1'b0;
  assign o_vld = ~empty;
  assign o_dat = mem_q[rptr[AW-1:0]];
`endif

  // A bypassed beat is consumed directly, so it never occupies a slot.
  assign wr_en = push & ~byp;

  gnrl_fifo_ptr #(.W(AW+1)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_en),
    .ptr_o (wptr)
  );

  gnrl_fifo_ptr #(.W(AW+1)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop),
    .ptr_o (rptr)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr[AW-1:0]] <= i_dat;
  end

`ifndef FPGA_SOURCE
  a_hsk_known: assert property (@(posedge clk) disable iff (rst) !$isunknown({i_vld, o_rdy}))
    else $error("gnrl_fifo: unknown value on i_vld/o_rdy");
`endif
endmodule
